// File: rtl/mod_counter_pkg.sv
// Shared mode constants and the modulo next-count function used by mod_counter.
// Arithmetic is carried out in CW bits, so a modulus of 2**N never overflows.
package mod_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int CW = 33;
  localparam logic [CW-1:0] CW_ONE  = 33'd1;
  localparam logic [CW-1:0] CW_ZERO = 33'd0;

  // Returns {event, next_q}. The step is clamped to mod-1. An event is a wrap or a
  // saturation, including an attempted move past the limit when q is already there.
  function automatic logic [CW:0] next_count(
    input logic [CW-1:0] q,
    input logic [CW-1:0] step,
    input logic          dir,
    input logic [CW-1:0] mod,
    input logic          sat
  );
    logic [CW-1:0] lim;
    logic [CW-1:0] s;
    logic [CW-1:0] t;
    logic          evt;
    lim = mod - CW_ONE;
    s   = (step > lim) ? lim : step;
    evt = 1'b0;
    t   = q;
    if (dir) begin
      if (q + s > lim) begin
        evt = 1'b1;
        t   = sat ? lim : (q + s - mod);
      end else begin
        t = q + s;
      end
    end else begin
      if (s <= q) begin
        t = q - s;
      end else begin
        evt = 1'b1;
        t   = sat ? CW_ZERO : (q + mod - s);
      end
    end
    return {evt, t};
  endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// Enable prescaler: adv pulses on every PRESCALE-th enabled cycle.
// With PRESCALE = 1 the counter stays at zero and adv is simply en.
module prescaler
  import mod_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic adv
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 32'd1);
  localparam logic [PW-1:0] ONE  = PW'(32'd1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign adv = en & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {PW{1'b0}};
    end else if (adv) begin
      cnt_d = {PW{1'b0}};
    end else if (en) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {PW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with clamped step, parallel load, wrap/saturate handling,
// enable prescaler, one-cycle terminal-count pulse and sticky overflow flag.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int          N        = 8,
  parameter int unsigned MOD      = 2**N,
  parameter int          SATURATE = 0,
  parameter int unsigned PRESCALE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         dir,
  input  logic [N-1:0] step,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         ovf
);

  localparam logic [CW-1:0] MOD_W    = CW'(MOD);
  localparam logic [N-1:0]  LIM      = N'(MOD - 32'd1);
  localparam logic          SAT_MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  logic [N-1:0] q_q, q_d;
  logic         tc_q, tc_d;
  logic         ovf_q, ovf_d;
  logic         adv_s;
  logic [CW:0]  nc_s;
  logic [N-1:0] load_clamp_s;
  logic         unused_s;

  // Load and clear also restart the prescaler so the next advance is a full interval away.
  prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (clr | load),
    .en    (en),
    .adv   (adv_s)
  );

  assign nc_s         = next_count(CW'(q_q), CW'(step), dir, MOD_W, SAT_MODE);
  assign load_clamp_s = (load_val > LIM) ? LIM : load_val;
  assign unused_s     = ^nc_s[CW-1:N];

  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (clr) begin
      q_d   = {N{1'b0}};
      ovf_d = 1'b0;
    end else if (load) begin
      q_d = load_clamp_s;
    end else if (adv_s) begin
      q_d   = nc_s[N-1:0];
      tc_d  = nc_s[CW];
      ovf_d = ovf_q | nc_s[CW];
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q   <= {N{1'b0}};
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule
